// File: rtl/bram_read_pipe.sv
// bram_read_pipe: read-request front end for BRAM port B (read-only).
// Drives port B enable/address/regce to match the BRAM's two-stage read,
// and captures returned words into a response FIFO. The pipeline only accepts
// a request when there is a free credit, so downstream backpressure never drops data.
// Optional feature macro: BRAM_READ_PIPE_BYPASS_EN. When it is defined, a word
// arriving while the FIFO is empty and resp_ready=1 goes straight to the
// response port, which gives 2-cycle latency.
module bram_read_pipe #(
    parameter int unsigned RAM_WIDTH  = 18,
    parameter int unsigned RAM_DEPTH  = 1024,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned ADDR_W    = $clog2(RAM_DEPTH),
    localparam int unsigned OCC_W     = $clog2(FIFO_DEPTH + 1) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [RAM_WIDTH-1:0] resp_data,
    output logic                 bram_en,
    output logic [ADDR_W-1:0]    bram_addr,
    output logic                 bram_regce,
    input  logic [RAM_WIDTH-1:0] bram_dout,
    output logic [OCC_W-1:0]     occupancy
);

    localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W   = FIFO_AW + 1;

    logic                 s1_q, s1_d;
    logic                 s2_q, s2_d;
    logic [ADDR_W-1:0]    bram_addr_q, bram_addr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [RAM_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]     fifo_count;
    logic [OCC_W-1:0]     occ;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 bypass;

    // Credit accounting, request side and BRAM port B drive
    always_comb begin
        fifo_count  = wr_ptr_q - rd_ptr_q;
        fifo_empty  = (wr_ptr_q == rd_ptr_q);
        fifo_full   = (fifo_count == PTR_W'(FIFO_DEPTH));
        occ         = OCC_W'(s1_q) + OCC_W'(s2_q) + OCC_W'(fifo_count);
        occupancy   = occ;
        req_ready   = !reset && (occ < OCC_W'(FIFO_DEPTH));
        accept      = req_valid && req_ready;
        bram_en     = accept;
        bram_addr   = accept ? req_addr : bram_addr_q;
        bram_regce  = s1_q;
        bram_addr_d = bram_addr;
        s1_d        = accept;
        s2_d        = s1_q;
    end

    // Response side: FIFO head (or, with bypass, the word arriving this cycle)
    always_comb begin
`ifdef BRAM_READ_PIPE_BYPASS_EN
        bypass     = s2_q && fifo_empty && resp_ready;
        resp_valid = !fifo_empty || bypass;
        resp_data  = fifo_empty ? bram_dout : fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]];
`else
        bypass     = 1'b0;
        resp_valid = !fifo_empty;
        resp_data  = fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]];
`endif
        push     = s2_q && !bypass;
        pop      = !fifo_empty && resp_ready;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    // Pipeline stage valids, held address and FIFO pointers
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            bram_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            bram_addr_q <= bram_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // FIFO storage; cleared on reset so resp_data reads zero afterwards
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else if (push) begin
            fifo_mem_q[wr_ptr_q[FIFO_AW-1:0]] <= bram_dout;
        end
    end

    // Credits guarantee a push never lands on a full FIFO
    assert property (@(posedge clock) disable iff (reset) !(push && fifo_full))
        else $error("bram_read_pipe: response FIFO overflow");

endmodule

// File: tb/tb_bram_read_pipe.sv
// Self-checking bench for bram_read_pipe with a two-stage BRAM port B model.
module tb_bram_read_pipe;

    localparam int unsigned RW = 18;
    localparam int unsigned AW = 10;
    localparam int unsigned OW = 4;
`ifdef BRAM_READ_PIPE_BYPASS_EN
    localparam bit BYP = 1'b1;
    localparam int LAT = 2;
`else
    localparam bit BYP = 1'b0;
    localparam int LAT = 3;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [RW-1:0] resp_data;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic          bram_regce;
    logic [RW-1:0] bram_dout;
    logic [OW-1:0] occupancy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pops = 0;
    bit chk_en = 1'b0;

    bram_read_pipe dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .bram_en    (bram_en),
        .bram_addr  (bram_addr),
        .bram_regce (bram_regce),
        .bram_dout  (bram_dout),
        .occupancy  (occupancy)
    );

    always #5 clock = ~clock;

    // BRAM port B: array latch on en, output register on regce, reset zeroes output
    logic [RW-1:0] mem [1024];
    logic [RW-1:0] latch_q = '0;
    logic [RW-1:0] dout_q = '0;
    always @(posedge clock) begin
        if (bram_en) latch_q <= mem[bram_addr];
        if (reset) dout_q <= '0;
        else if (bram_regce) dout_q <= latch_q;
    end
    assign bram_dout = dout_q;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) chk_en <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: queue of accepted, not yet delivered reads
    typedef struct {
        logic [RW-1:0] data;
        int            acc;
    } ent_t;
    ent_t          q[$];
    logic [AW-1:0] last_addr = '0;
    bit            prev_acc = 1'b0;

    always @(negedge clock) begin
        if (chk_en) begin
            int  occ_e;
            bit  rdy_e;
            bit  vis;
            bit  acc;
            occ_e = q.size();
            rdy_e = !reset && (occ_e < 4);
            vis   = (q.size() > 0) &&
                    ((q[0].acc + 3 <= cyc) || (BYP && (q[0].acc + 2 == cyc) && resp_ready));
            acc   = req_valid && rdy_e;
            chk("req_ready", 32'(req_ready), 32'(rdy_e));
            chk("occupancy", 32'(occupancy), 32'(occ_e));
            chk("resp_valid", 32'(resp_valid), 32'(vis));
            if (vis) chk("resp_data", 32'(resp_data), 32'(q[0].data));
            chk("bram_en", 32'(bram_en), 32'(acc));
            chk("bram_addr", 32'(bram_addr), 32'(acc ? req_addr : last_addr));
            chk("bram_regce", 32'(bram_regce), 32'(prev_acc));
            if (reset) begin
                q.delete();
                last_addr = '0;
                prev_acc  = 1'b0;
            end else begin
                if (vis && resp_ready) begin
                    void'(q.pop_front());
                    pops++;
                end
                if (acc) begin
                    q.push_back('{data: mem[req_addr], acc: cyc});
                    last_addr = req_addr;
                end
                prev_acc = acc;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n_acc;
        int base;
        int sent;
        for (int i = 0; i < 1024; i++) mem[i] = RW'(i);
        mem[5] = 18'h2A5A5;

        // Reset values while reset is still held
        tick();
        tick();
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_bram_en", 32'(bram_en), 32'd0);
        chk("rst_bram_addr", 32'(bram_addr), 32'd0);
        chk("rst_bram_regce", 32'(bram_regce), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Single read of address 5 accepted at cycle 10
        while (cyc < 10) tick();
        req_valid  = 1'b1;
        req_addr   = 10'd5;
        resp_ready = 1'b1;
        #1;
        chk("single_accept", 32'(req_ready), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            req_valid = 1'b0;
            #1;
            if (k == LAT - 1) chk("single_early", 32'(resp_valid), 32'd0);
            if (k == LAT) begin
                chk("single_valid", 32'(resp_valid), 32'd1);
                chk("single_data", 32'(resp_data), 32'h2A5A5);
            end
        end
        chk("single_occ_zero", 32'(occupancy), 32'd0);
        mem[5] = RW'(5);

        // Streaming 0..15 with resp_ready held high
        base = pops;
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1;
            req_addr  = AW'(i);
            #1;
            chk("stream_ready", 32'(req_ready), 32'd1);
            tick();
        end
        req_valid = 1'b0;
        repeat (6) tick();
        chk("stream_count", 32'(pops - base), 32'd16);

        // Backpressure until full, then a single pop
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 10'd40;
        n_acc = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (req_ready) n_acc++;
            tick();
            req_addr = AW'(40 + n_acc);
        end
        req_valid = 1'b0;
        #1;
        chk("full_accepts", 32'(n_acc), 32'd4);
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd4);
        resp_ready = 1'b1;
        #1;
        chk("pop_cycle_ready", 32'(req_ready), 32'd0);
        tick();
        resp_ready = 1'b0;
        #1;
        chk("credit_ready", 32'(req_ready), 32'd1);
        chk("credit_occ", 32'(occupancy), 32'd3);
        resp_ready = 1'b1;
        repeat (6) tick();

        // Wrap-around: 3 rounds of 4 reads, resp_ready toggling
        base = pops;
        sent = 0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 20 && sent < 4 * (r + 1); k++) begin
                resp_ready = (cyc % 2 == 0);
                req_valid  = 1'b1;
                req_addr   = AW'(200 + sent);
                #1;
                if (req_ready) sent++;
                tick();
            end
            req_valid = 1'b0;
            resp_ready = (cyc % 2 == 0);
            tick();
        end
        for (int k = 0; k < 24; k++) begin
            resp_ready = (cyc % 2 == 0);
            tick();
        end
        chk("wrap_sent", 32'(sent), 32'd12);
        chk("wrap_count", 32'(pops - base), 32'd12);

        // Stability under backpressure
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 10'd300;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_data", 32'(resp_data), 32'd300);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Reset one cycle after the last of three accepts
        for (int a = 1; a <= 3; a++) begin
            req_valid = 1'b1;
            req_addr  = AW'(a);
            tick();
        end
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("rst_flight_quiet", 32'(resp_valid), 32'd0);
            tick();
        end
        base = pops;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 10'd7;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            #1;
            if (k == LAT - 1) chk("after_rst_data", 32'(resp_data), 32'd7);
        end
        chk("after_rst_count", 32'(pops - base), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_read_pipe.md
# bram_read_pipe

Read-request front end for the true-dual-port BRAM's read-only port B in the cache arrays. Accepts read addresses over a valid/ready handshake, drives port B enable, address and output-register enable to match the BRAM's two-stage read (array latch, then output register), and captures returned words into a small response FIFO so downstream backpressure never loses data. Credit-based flow control bounds outstanding reads to the FIFO capacity.

## Interface
- RAM_WIDTH, 18, BRAM word width; must match the attached BRAM.
- RAM_DEPTH, 1024, BRAM entries; address width ADDR_W = clogb2(RAM_DEPTH-1), same function as the BRAM.
- FIFO_DEPTH, 4, response FIFO entries; power of two, minimum 4.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; also wired to the BRAM's output-register reset.
- req_valid  in  1  read request present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_addr  in  ADDR_W  read address.
- resp_valid  out  1  resp_data valid.
- resp_ready  in  1  consumer takes the response this cycle.
- resp_data  out  RAM_WIDTH  read word, in request order.
- bram_en  out  1  to BRAM port B enable.
- bram_addr  out  ADDR_W  to BRAM port B address.
- bram_regce  out  1  to BRAM port B output-register enable.
- bram_dout  in  RAM_WIDTH  from BRAM port B data output.
- occupancy  out  clogb2(FIFO_DEPTH)+1  outstanding reads plus FIFO entries.

## Operation
- Accept = req_valid && req_ready. On accept: bram_en=1, bram_addr=req_addr, combinational in the accept cycle T. When there is no accept: bram_en=0 and bram_addr holds its last driven value.
- Stage valids: s1 is set at the end of T. bram_regce = s1 in T+1. s2 is set at the end of T+1. In T+2, bram_dout holds the word and s2=1; the word is pushed into the FIFO at the end of T+2.
- occupancy = s1 + s2 + fifo_count. req_ready = (occupancy < FIFO_DEPTH), combinational from registered state only. It does not depend on req_valid or resp_ready.
- Because of the credit scheme, a push never finds the FIFO full. An internal overflow is an assertion failure.
- FIFO: circular buffer. Pointers are ADDR-of-FIFO wide plus one wrap bit. empty = pointers equal. resp_valid = !empty. resp_data = entry at the read pointer, registered storage.
- A push and a pop in the same cycle are both performed; count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- In-order delivery is guaranteed: a single pipeline and a single FIFO.
- Back-to-back accepts are allowed every cycle while credits remain. Sustained throughput is 1 word/cycle when resp_ready is held high.

## Timing
- Reset values: req_ready=0 in the reset cycle, then 1. resp_valid=0, resp_data=0, bram_en=0, bram_addr=0, bram_regce=0, occupancy=0. s1, s2 and the FIFO pointers are cleared.
- Reset mid-operation: all in-flight reads and FIFO contents are discarded. No response for pre-reset requests is ever emitted. The BRAM output register is also zeroed by the shared reset.
- Latency, accept at T (default build): resp_valid first high in cycle T+3.
- Backpressure: resp_valid and resp_data hold stable while resp_ready=0.
- FIFO full (occupancy==FIFO_DEPTH): req_ready=0. It returns to 1 in the cycle after a pop frees a credit.
- Simultaneous accept and pop at occupancy==FIFO_DEPTH is impossible, because req_ready=0 in that state. One cycle of bubble is accepted.

## Configuration
- BRAM_READ_PIPE_BYPASS_EN defined: in T+2, if the FIFO is empty and resp_ready=1, resp_valid=1 and resp_data=bram_dout combinationally, and the word is not pushed. Latency is 2 cycles. If the bypass is not taken (FIFO non-empty or resp_ready=0), the word is pushed as normal.
- BRAM_READ_PIPE_BYPASS_EN undefined: resp_data is always from FIFO storage. Latency is 3 cycles. There is no combinational path from bram_dout or resp_ready to resp_*.

## Test plan
- Single read: the BRAM is preloaded with mem[5]=18'h2A5A5. Stimulus: req_addr=5 accepted at cycle 10. Required: resp_valid high at cycle 13 with resp_data=18'h2A5A5 (cycle 12 with bypass); occupancy returns to 0 after the pop.
- Streaming: with mem[i]=i, accept addresses 0..15 on consecutive cycles with resp_ready=1. Required: 16 responses 0..15 in order on consecutive cycles; req_ready never drops.
- Backpressure/full: with resp_ready=0 and req_valid held high, exactly 4 requests are accepted. Required: req_ready=0 with occupancy=4. Raise resp_ready for one cycle: one word pops and req_ready returns to 1 on the next cycle.
- Wrap-around: 3 rounds of 4 reads each, with resp_ready toggling 1/0 on alternate cycles. Required: all 12 words correct and in order; the pointers wrap without loss.
- Reset mid-flight: accept 3 reads, then assert reset 1 cycle after the last accept. Required: resp_valid stays 0 for the following 10 cycles. Next request addr=7 returns mem[7] only.
- Stability: with resp_valid=1 and resp_ready=0 held for 5 cycles, resp_data is unchanged throughout.
